// File: rtl/pipe_control.sv
// Pipelined DLX control: decodes the ID instruction and carries the control
// bundle through ID/EX, EX/MEM and MEM/WB, with load-use stall and branch flush.
module pipe_control #(
  parameter int REG_AW         = 5,
  parameter int ALUCTR_W       = 4,
  parameter int LOAD_USE_STALL = 1,
  parameter int FP_ENABLE      = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [0:31]         instr,
  input  logic                instr_valid,
  input  logic                br_taken,
  output logic                stall,
  output logic                flush,
  output logic                ex_valid,
  output logic                ex_regdst,
  output logic                ex_alusrc,
  output logic                ex_extop,
  output logic                ex_branch,
  output logic                ex_bne,
  output logic                ex_jump,
  output logic                ex_jumpreg,
  output logic [ALUCTR_W-1:0] ex_aluctr,
  output logic                mem_valid,
  output logic                mem_memwr,
  output logic                mem_mem2reg,
  output logic                wb_valid,
  output logic                wb_regwr,
  output logic                wb_regfp_wr,
  output logic [REG_AW-1:0]   wb_rd
);

  typedef struct packed {
    logic                valid;
    logic                regdst;
    logic                alusrc;
    logic                extop;
    logic                branch;
    logic                bne;
    logic                jump;
    logic                jumpreg;
    logic [ALUCTR_W-1:0] aluctr;
    logic                memwr;
    logic                mem2reg;
    logic                regwr;
    logic                regfp_wr;
    logic [REG_AW-1:0]   rd;
  } ctl_t;

  logic [5:0]        opcode;
  logic [5:0]        func;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic [REG_AW-1:0] rd_r;
  logic              unused_shamt;

  assign opcode       = instr[0:5];
  assign rs1          = instr[6:10];
  assign rs2          = instr[11:15];
  assign rd_r         = instr[16:20];
  assign func         = instr[26:31];
  assign unused_shamt = ^instr[21:25];

  ctl_t              dec;
  ctl_t              ex_q;
  ctl_t              ex_d;
  logic              use_rs1;
  logic              use_rs2;
  logic              int_wr;
  logic              fp_wr;
  logic              r_ok;
  logic [REG_AW-1:0] dest;
  logic              hazard;

  always_comb begin
    dec     = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    int_wr  = 1'b0;
    fp_wr   = 1'b0;
    r_ok    = 1'b0;
    dest    = rs2;
    if (instr_valid) begin
      case (opcode)
        6'h00: begin
          dest = rd_r;
          case (func)
            6'h20: begin r_ok = 1'b1; int_wr = 1'b1; dec.aluctr = ALUCTR_W'(4'b0000); end
            6'h22: begin r_ok = 1'b1; int_wr = 1'b1; dec.aluctr = ALUCTR_W'(4'b0001); end
            6'h24: begin r_ok = 1'b1; int_wr = 1'b1; dec.aluctr = ALUCTR_W'(4'b0010); end
            6'h04: begin r_ok = 1'b1; int_wr = 1'b1; dec.aluctr = ALUCTR_W'(4'b0101); end
            6'h29: begin r_ok = 1'b1; int_wr = 1'b1; dec.aluctr = ALUCTR_W'(4'b1001); end
            6'h34: if (FP_ENABLE != 0) begin r_ok = 1'b1; int_wr = 1'b1; end
            6'h35: if (FP_ENABLE != 0) begin r_ok = 1'b1; fp_wr = 1'b1; end
            default: ;
          endcase
          if (r_ok) begin
            dec.valid  = 1'b1;
            dec.regdst = 1'b1;
            use_rs1    = 1'b1;
            use_rs2    = 1'b1;
          end
        end
        6'h08: begin
          dec.valid = 1'b1; dec.alusrc = 1'b1; dec.extop = 1'b1;
          int_wr = 1'b1; use_rs1 = 1'b1; dec.aluctr = ALUCTR_W'(4'b0000);
        end
        6'h09: begin
          dec.valid = 1'b1; dec.alusrc = 1'b1;
          int_wr = 1'b1; use_rs1 = 1'b1; dec.aluctr = ALUCTR_W'(4'b0000);
        end
        6'h0C: begin
          dec.valid = 1'b1; dec.alusrc = 1'b1;
          int_wr = 1'b1; use_rs1 = 1'b1; dec.aluctr = ALUCTR_W'(4'b0010);
        end
        6'h0E: begin
          dec.valid = 1'b1; dec.alusrc = 1'b1;
          int_wr = 1'b1; use_rs1 = 1'b1; dec.aluctr = ALUCTR_W'(4'b0100);
        end
        6'h16: begin
          dec.valid = 1'b1; dec.alusrc = 1'b1;
          int_wr = 1'b1; use_rs1 = 1'b1; dec.aluctr = ALUCTR_W'(4'b0110);
        end
        6'h23: begin
          dec.valid = 1'b1; dec.alusrc = 1'b1; dec.extop = 1'b1; dec.mem2reg = 1'b1;
          int_wr = 1'b1; use_rs1 = 1'b1;
        end
        6'h2B, 6'h28: begin
          dec.valid = 1'b1; dec.alusrc = 1'b1; dec.extop = 1'b1; dec.memwr = 1'b1;
          use_rs1 = 1'b1; use_rs2 = 1'b1;
        end
        6'h04: begin dec.valid = 1'b1; dec.branch = 1'b1; use_rs1 = 1'b1; end
        6'h05: begin dec.valid = 1'b1; dec.branch = 1'b1; dec.bne = 1'b1; use_rs1 = 1'b1; end
        6'h02: begin dec.valid = 1'b1; dec.jump = 1'b1; end
        6'h12: begin dec.valid = 1'b1; dec.jumpreg = 1'b1; use_rs1 = 1'b1; end
        default: ;
      endcase
    end
    // r0 is hardwired: integer writes to it are dropped, FP writes are not
    dec.regwr    = int_wr && (dest != '0);
    dec.regfp_wr = fp_wr;
    dec.rd       = (int_wr || fp_wr) ? dest : '0;
  end

  always_comb begin
    hazard = (LOAD_USE_STALL != 0) && ex_q.valid && ex_q.mem2reg && (ex_q.rd != '0) &&
             ((use_rs1 && (rs1 == ex_q.rd)) || (use_rs2 && (rs2 == ex_q.rd)));
    // A taken branch squashes the ID instruction anyway, so it overrides the stall
    stall = hazard && !br_taken;
    flush = br_taken;
    ex_d  = (br_taken || hazard) ? '0 : dec;
  end

  logic              mem_regwr_q;
  logic              mem_regfp_wr_q;
  logic [REG_AW-1:0] mem_rd_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q           <= '0;
      mem_valid      <= 1'b0;
      mem_memwr      <= 1'b0;
      mem_mem2reg    <= 1'b0;
      mem_regwr_q    <= 1'b0;
      mem_regfp_wr_q <= 1'b0;
      mem_rd_q       <= '0;
      wb_valid       <= 1'b0;
      wb_regwr       <= 1'b0;
      wb_regfp_wr    <= 1'b0;
      wb_rd          <= '0;
    end else begin
      ex_q           <= ex_d;
      mem_valid      <= ex_q.valid;
      mem_memwr      <= ex_q.memwr;
      mem_mem2reg    <= ex_q.mem2reg;
      mem_regwr_q    <= ex_q.regwr;
      mem_regfp_wr_q <= ex_q.regfp_wr;
      mem_rd_q       <= ex_q.rd;
      wb_valid       <= mem_valid;
      wb_regwr       <= mem_regwr_q;
      wb_regfp_wr    <= mem_regfp_wr_q;
      wb_rd          <= mem_rd_q;
    end
  end

  assign ex_valid   = ex_q.valid;
  assign ex_regdst  = ex_q.regdst;
  assign ex_alusrc  = ex_q.alusrc;
  assign ex_extop   = ex_q.extop;
  assign ex_branch  = ex_q.branch;
  assign ex_bne     = ex_q.bne;
  assign ex_jump    = ex_q.jump;
  assign ex_jumpreg = ex_q.jumpreg;
  assign ex_aluctr  = ex_q.aluctr;

endmodule

// File: tb/tb_pipe_control.sv
// Directed bench for pipe_control: decode, pipeline latency, load-use stall,
// flush priority, FP disable and asynchronous reset.
module tb_pipe_control;

  logic        clk;
  logic        reset;
  logic [0:31] instr;
  logic        instr_valid;
  logic        br_taken;

  logic       stall, flush;
  logic       ex_valid, ex_regdst, ex_alusrc, ex_extop, ex_branch, ex_bne, ex_jump, ex_jumpreg;
  logic [3:0] ex_aluctr;
  logic       mem_valid, mem_memwr, mem_mem2reg;
  logic       wb_valid, wb_regwr, wb_regfp_wr;
  logic [4:0] wb_rd;

  logic       stall_f, flush_f;
  logic       ex_valid_f, ex_regdst_f, ex_alusrc_f, ex_extop_f, ex_branch_f, ex_bne_f, ex_jump_f, ex_jumpreg_f;
  logic [3:0] ex_aluctr_f;
  logic       mem_valid_f, mem_memwr_f, mem_mem2reg_f;
  logic       wb_valid_f, wb_regwr_f, wb_regfp_wr_f;
  logic [4:0] wb_rd_f;

  int unsigned n_checks;
  int unsigned n_fail;

  pipe_control #(.REG_AW(5), .ALUCTR_W(4), .LOAD_USE_STALL(1), .FP_ENABLE(1)) dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid), .br_taken(br_taken),
    .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_regdst(ex_regdst), .ex_alusrc(ex_alusrc), .ex_extop(ex_extop),
    .ex_branch(ex_branch), .ex_bne(ex_bne), .ex_jump(ex_jump), .ex_jumpreg(ex_jumpreg),
    .ex_aluctr(ex_aluctr),
    .mem_valid(mem_valid), .mem_memwr(mem_memwr), .mem_mem2reg(mem_mem2reg),
    .wb_valid(wb_valid), .wb_regwr(wb_regwr), .wb_regfp_wr(wb_regfp_wr), .wb_rd(wb_rd)
  );

  pipe_control #(.REG_AW(5), .ALUCTR_W(4), .LOAD_USE_STALL(1), .FP_ENABLE(0)) dut_nofp (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid), .br_taken(br_taken),
    .stall(stall_f), .flush(flush_f),
    .ex_valid(ex_valid_f), .ex_regdst(ex_regdst_f), .ex_alusrc(ex_alusrc_f), .ex_extop(ex_extop_f),
    .ex_branch(ex_branch_f), .ex_bne(ex_bne_f), .ex_jump(ex_jump_f), .ex_jumpreg(ex_jumpreg_f),
    .ex_aluctr(ex_aluctr_f),
    .mem_valid(mem_valid_f), .mem_memwr(mem_memwr_f), .mem_mem2reg(mem_mem2reg_f),
    .wb_valid(wb_valid_f), .wb_regwr(wb_regwr_f), .wb_regfp_wr(wb_regfp_wr_f), .wb_rd(wb_rd_f)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] w, input logic v);
    instr       = w;
    instr_valid = v;
  endtask

  localparam logic [31:0] ADDI_R1   = 32'h2021_0005;
  localparam logic [31:0] ADD_R3    = 32'h0022_1820;
  localparam logic [31:0] ADD_R0    = 32'h0022_0020;
  localparam logic [31:0] LW_R2     = 32'h8C22_0000;
  localparam logic [31:0] LW_R0     = 32'h8C20_0000;
  localparam logic [31:0] ADD_USE0  = 32'h0000_1820;
  localparam logic [31:0] ADD_R4R5  = 32'h0085_1820;
  localparam logic [31:0] SW_R2     = 32'hAC22_0000;
  localparam logic [31:0] BEQZ_R1   = 32'h1020_0000;
  localparam logic [31:0] BNEZ_R1   = 32'h1420_0000;
  localparam logic [31:0] J_0       = 32'h0800_0000;
  localparam logic [31:0] MOVI2FP   = 32'h0000_0035;

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    reset       = 1'b1;
    br_taken    = 1'b0;
    drive(32'h0, 1'b0);
    #12;
    check("rst_ex_valid", ex_valid, 0);
    check("rst_mem_valid", mem_valid, 0);
    check("rst_wb_regwr", wb_regwr, 0);
    check("rst_wb_rd", wb_rd, 0);
    check("rst_stall", stall, 0);
    check("rst_flush", flush, 0);
    reset = 1'b0;

    // addi, add rd=3, add rd=0 flowing through
    drive(ADDI_R1, 1'b1);
    step();
    check("addi_ex_valid", ex_valid, 1);
    check("addi_alusrc", ex_alusrc, 1);
    check("addi_extop", ex_extop, 1);
    check("addi_aluctr", ex_aluctr, 4'b0000);
    check("addi_regdst", ex_regdst, 0);
    drive(ADD_R3, 1'b1);
    step();
    check("add_regdst", ex_regdst, 1);
    check("add_aluctr", ex_aluctr, 4'b0000);
    check("add_alusrc", ex_alusrc, 0);
    check("addi_mem_valid", mem_valid, 1);
    drive(ADD_R0, 1'b1);
    step();
    check("addi_wb_regwr", wb_regwr, 1);
    check("addi_wb_rd", wb_rd, 1);
    drive(32'h0, 1'b0);
    step();
    check("bubble_ex_valid", ex_valid, 0);
    check("add_wb_regwr", wb_regwr, 1);
    check("add_wb_rd", wb_rd, 3);
    step();
    check("addr0_wb_valid", wb_valid, 1);
    check("addr0_wb_regwr", wb_regwr, 0);

    // load-use on rs2
    drive(LW_R2, 1'b1);
    step();
    check("lw_ex_valid", ex_valid, 1);
    drive(ADD_R3, 1'b1);
    #1;
    check("lu_stall", stall, 1);
    check("lu_flush", flush, 0);
    step();
    check("lu_ex_bubble", ex_valid, 0);
    check("lu_mem_mem2reg", mem_mem2reg, 1);
    check("lu_stall_clear", stall, 0);
    step();
    check("lu_add_in_ex", ex_valid, 1);
    check("lu_add_regdst", ex_regdst, 1);
    check("lw_wb_regwr", wb_regwr, 1);
    check("lw_wb_rd", wb_rd, 2);

    // load to r0 then use r0; load r2 then unrelated use
    drive(LW_R0, 1'b1);
    step();
    drive(ADD_USE0, 1'b1);
    #1;
    check("r0_no_stall", stall, 0);
    step();
    drive(LW_R2, 1'b1);
    step();
    drive(ADD_R4R5, 1'b1);
    #1;
    check("unrel_no_stall", stall, 0);
    step();
    check("unrel_ex_valid", ex_valid, 1);

    // hazard and taken branch together
    drive(LW_R2, 1'b1);
    step();
    drive(ADD_R3, 1'b1);
    br_taken = 1'b1;
    #1;
    check("brhz_stall", stall, 0);
    check("brhz_flush", flush, 1);
    step();
    check("brhz_ex_bubble", ex_valid, 0);
    br_taken = 1'b0;
    #1;
    check("flush_low", flush, 0);

    // store, branches, jump
    drive(SW_R2, 1'b1);
    step();
    check("sw_alusrc", ex_alusrc, 1);
    drive(BEQZ_R1, 1'b1);
    step();
    check("sw_mem_memwr", mem_memwr, 1);
    check("beqz_branch", ex_branch, 1);
    check("beqz_bne", ex_bne, 0);
    drive(BNEZ_R1, 1'b1);
    step();
    check("bnez_bne", ex_bne, 1);
    drive(J_0, 1'b1);
    step();
    check("j_jump", ex_jump, 1);
    check("j_branch", ex_branch, 0);

    // movi2fp with and without FP decode
    drive(MOVI2FP, 1'b1);
    step();
    check("movi2fp_ex_valid", ex_valid, 1);
    check("nofp_movi2fp_bubble", ex_valid_f, 0);
    drive(32'h0, 1'b0);
    step();
    step();
    check("movi2fp_wb_fpwr", wb_regfp_wr, 1);
    check("movi2fp_wb_regwr", wb_regwr, 0);

    // asynchronous reset mid-stream
    drive(ADDI_R1, 1'b1);
    step();
    drive(32'h0, 1'b0);
    step();
    step();
    check("pre_rst_wb_regwr", wb_regwr, 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_wb_regwr", wb_regwr, 0);
    check("async_rst_wb_rd", wb_rd, 0);
    drive(ADDI_R1, 1'b1);
    #2;
    reset = 1'b0;
    step();
    check("post_rst_ex_valid", ex_valid, 1);
    check("post_rst_wb_valid", wb_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
